// File: rtl/usb_skp_inserter.sv
// Transmit-side SKP ordered-set scheduler feeding the PHY elastic FIFO write port.
// Inserts a disparity-matched K28.1 pair after every SKP_INTERVAL counted data symbols.
module usb_skp_inserter #(
  parameter int unsigned SKP_INTERVAL = 354,
  parameter int unsigned CNT_W        = 12
) (
  input  logic        wclk,
  input  logic        wrst_n,
  input  logic [9:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        skp_en,
  output logic [9:0]  wdata,
  output logic        winc,
  input  logic        wfull,
  output logic        rd,
  output logic [15:0] skp_cnt
);

  localparam logic [9:0]       SkpRdNeg = 10'h0F9;
  localparam logic [9:0]       SkpRdPos = 10'h306;
  localparam logic [CNT_W-1:0] Interval = CNT_W'(SKP_INTERVAL);

  typedef enum logic {StData, StSkp2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [15:0]      skp_cnt_q, skp_cnt_d;
  logic             rd_q, rd_d;
  logic [9:0]       wdata_q, wdata_d;
  logic             winc_q, winc_d;

  logic       slot_free;
  logic       skp_due;
  logic       load;
  logic [9:0] load_sym;
  logic [9:0] skp_sym;
  logic [3:0] load_ones;

  assign slot_free = !winc_q || !wfull;
  assign skp_due   = skp_en && (sym_cnt_q >= Interval);
  // The form matching the current rd; the second SKP of a pair sees the flipped rd.
  assign skp_sym   = rd_q ? SkpRdPos : SkpRdNeg;

  // State register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= StData;
      sym_cnt_q <= '0;
      skp_cnt_q <= '0;
      rd_q      <= 1'b0;
      wdata_q   <= 10'h000;
      winc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      skp_cnt_q <= skp_cnt_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      winc_q    <= winc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StData:  if (slot_free && skp_due) state_d = StSkp2;
      StSkp2:  if (slot_free) state_d = StData;
      default: state_d = StData;
    endcase
  end

  // Datapath next values
  always_comb begin
    load      = 1'b0;
    load_sym  = wdata_q;
    sym_cnt_d = sym_cnt_q;
    skp_cnt_d = skp_cnt_q;
    winc_d    = winc_q;
    if (slot_free) begin
      winc_d = 1'b0;
      unique case (state_q)
        StData: begin
          if (skp_due) begin
            load     = 1'b1;
            load_sym = skp_sym;
          end else if (in_valid) begin
            load     = 1'b1;
            load_sym = in_data;
            if (skp_en && (sym_cnt_q != '1)) sym_cnt_d = sym_cnt_q + CNT_W'(1);
          end
        end
        StSkp2: begin
          load      = 1'b1;
          load_sym  = skp_sym;
          sym_cnt_d = '0;
          skp_cnt_d = skp_cnt_q + 16'd1;
        end
        default: ;
      endcase
      if (load) winc_d = 1'b1;
    end
    wdata_d = load ? load_sym : wdata_q;
  end

  // Running disparity: neutral symbols (five ones) leave it unchanged.
  always_comb begin
    load_ones = 4'($countones(load_sym));
    rd_d      = rd_q;
    if (load) begin
      if (load_ones > 4'd5)      rd_d = 1'b1;
      else if (load_ones < 4'd5) rd_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    in_ready = slot_free && (state_q == StData) && !skp_due;
    wdata    = wdata_q;
    winc     = winc_q;
    rd       = rd_q;
    skp_cnt  = skp_cnt_q;
  end

endmodule

// File: tb/tb_usb_skp_inserter.sv
// Directed bench for usb_skp_inserter: a scoreboard models the written FIFO stream
// (data plus disparity-matched SKP pairs) and checks every transfer.
module tb_usb_skp_inserter;
  localparam int unsigned N = 4;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        skp_en;
  logic [9:0]  wdata;
  logic        winc;
  logic        wfull;
  logic        rd;
  logic [15:0] skp_cnt;

  usb_skp_inserter #(.SKP_INTERVAL(N), .CNT_W(12)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .skp_en   (skp_en),
    .wdata    (wdata),
    .winc     (winc),
    .wfull    (wfull),
    .rd       (rd),
    .skp_cnt  (skp_cnt)
  );

  always #5 wclk = ~wclk;

  int         tests = 0;
  int         fails = 0;
  logic [9:0] exp_q[$];
  int         m_cnt;
  logic       m_rd;
  int         zero_cnt;
  bit         meas;
  logic [9:0] tbl [4] = '{10'h2AA, 10'h3E8, 10'h017, 10'h155};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rd_after(input logic r, input logic [9:0] s);
    int p;
    p = $countones(s);
    if (p > 5) return 1'b1;
    if (p < 5) return 1'b0;
    return r;
  endfunction

  // Model: expected written stream in acceptance order.
  task automatic push_sym(input logic [9:0] sym, input bit en);
    logic [9:0] s;
    exp_q.push_back(sym);
    m_rd = rd_after(m_rd, sym);
    if (en) begin
      m_cnt++;
      if (m_cnt == N) begin
        for (int k = 0; k < 2; k++) begin
          s = m_rd ? 10'h306 : 10'h0F9;
          exp_q.push_back(s);
          m_rd = rd_after(m_rd, s);
        end
        m_cnt = 0;
      end
    end
  endtask

  task automatic send(input logic [9:0] sym, input bit en);
    bit acc;
    bit rdy;
    push_sym(sym, en);
    in_data  = sym;
    skp_en   = en;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge wclk);
      rdy = in_ready;
      @(posedge wclk);
      #1;
      acc = rdy;
    end
    in_valid = 1'b0;
    chk("accept", 16'(acc), 16'd1);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  // Scoreboard checker: a transfer happens on the coming edge when winc && !wfull.
  always @(negedge wclk) begin
    if (wrst_n && winc && !wfull) begin
      if (exp_q.size() == 0) chk("stream_extra", 16'(exp_q.size()), 16'd1);
      else chk("stream", 16'(wdata), 16'(exp_q.pop_front()));
    end
    if (meas && !in_ready) zero_cnt++;
  end

  initial begin
    wrst_n = 1'b0; in_valid = 1'b0; in_data = '0; skp_en = 1'b1; wfull = 1'b0;
    m_cnt = 0; m_rd = 1'b0; meas = 1'b0; zero_cnt = 0;
    #12;
    chk("rst_winc", 16'(winc), 16'd0);
    chk("rst_wdata", 16'(wdata), 16'h000);
    chk("rst_rd", 16'(rd), 16'd0);
    chk("rst_skp_cnt", skp_cnt, 16'd0);
    wrst_n = 1'b1;
    @(negedge wclk);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    @(posedge wclk); #1;

    // Basic insertion
    meas = 1'b1;
    repeat (8) send(10'h2AA, 1'b1);
    drain(6);
    meas = 1'b0;
    chk("basic_ready_low_cycles", 16'(zero_cnt), 16'd4);
    chk("basic_skp_cnt", skp_cnt, 16'd2);
    chk("basic_rd", 16'(rd), 16'd0);

    // Disparity form
    send(10'h3E8, 1'b1);
    repeat (3) send(10'h2AA, 1'b1);
    drain(6);
    chk("disp_rd", 16'(rd), 16'd1);
    chk("disp_skp_cnt", skp_cnt, 16'd3);

    // Backpressure inside a set
    send(10'h017, 1'b1);
    repeat (3) send(10'h2AA, 1'b1);
    @(posedge wclk); #1;
    wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      chk("bp_wdata", 16'(wdata), 16'h0F9);
      chk("bp_winc", 16'(winc), 16'd1);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
      chk("bp_rd", 16'(rd), 16'd1);
      chk("bp_skp_cnt", skp_cnt, 16'd3);
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
    drain(4);
    chk("bp_skp_cnt_after", skp_cnt, 16'd4);

    // Bypass: counter holds while disabled
    repeat (2) send(10'h2AA, 1'b1);
    for (int i = 0; i < 20; i++) send(tbl[i % 4], 1'b0);
    chk("bypass_skp_cnt_hold", skp_cnt, 16'd4);
    repeat (2) send(10'h2AA, 1'b1);
    drain(6);
    chk("bypass_skp_cnt", skp_cnt, 16'd5);

    // Idle gaps between symbols
    for (int i = 1; i <= 4; i++) begin
      send(10'h2AA, 1'b1);
      @(posedge wclk); #1;
      if (i < 4) chk("idle_winc", 16'(winc), 16'd0);
    end
    drain(6);
    chk("idle_skp_cnt", skp_cnt, 16'd6);

    // Asynchronous reset while in SKP2 under backpressure
    send(10'h017, 1'b1);
    repeat (3) send(10'h2AA, 1'b1);
    @(posedge wclk); #1;
    wfull = 1'b1;
    @(negedge wclk);
    chk("prerst_wdata", 16'(wdata), 16'h0F9);
    chk("prerst_rd", 16'(rd), 16'd1);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_winc", 16'(winc), 16'd0);
    chk("arst_rd", 16'(rd), 16'd0);
    chk("arst_skp_cnt", skp_cnt, 16'd0);
    chk("arst_wdata", 16'(wdata), 16'h000);
    exp_q.delete();
    m_cnt = 0;
    m_rd  = 1'b0;
    wfull = 1'b0;
    @(posedge wclk); #2;
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    repeat (4) send(10'h2AA, 1'b1);
    drain(6);
    chk("post_rst_skp_cnt", skp_cnt, 16'd1);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
